// File: rtl/stack_arbiter.sv
// stack_arbiter: shares a 5-deep external stack between requesters A and B.
// Round-robin grant, strobe-clock sequencing of the stack bus, occupancy
// tracking and rejection of pop/push/get operations that would under/overflow.
module stack_arbiter #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned DEPTH   = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               A_REQ,
  input  logic [1:0]         A_CMD,
  input  logic [INDEX_W-1:0] A_INDEX,
  input  logic [DATA_W-1:0]  A_WDATA,
  input  logic               B_REQ,
  input  logic [1:0]         B_CMD,
  input  logic [INDEX_W-1:0] B_INDEX,
  input  logic [DATA_W-1:0]  B_WDATA,
  output logic [1:0]         ACK,
  output logic [DATA_W-1:0]  RDATA,
  output logic               ERR,
  output logic [2:0]         COUNT,
  output logic               EMPTY,
  output logic               FULL,
  output logic               STK_RESET,
  output logic               STK_CLK,
  output logic [1:0]         STK_COMMAND,
  output logic [INDEX_W-1:0] STK_INDEX,
  inout  wire  [DATA_W-1:0]  STK_IO_DATA
);

  localparam logic [1:0] CmdNop  = 2'b00;
  localparam logic [1:0] CmdPush = 2'b01;
  localparam logic [1:0] CmdPop  = 2'b10;
  localparam logic [1:0] CmdGet  = 2'b11;

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StCapture, StRelease} state_e;

  state_e             r_state, w_state_d;
  logic [1:0]         r_cmd, w_cmd_d;
  logic [INDEX_W-1:0] r_index, w_index_d;
  logic [DATA_W-1:0]  r_wdata, w_wdata_d;
  logic               r_grant, w_grant_d;  // 0 = A, 1 = B
  logic               r_last, w_last_d;    // requester granted most recently
  logic [2:0]         r_count, w_count_d;
  logic [DATA_W-1:0]  r_rdata, w_rdata_d;
  logic [1:0]         r_ack, w_ack_d;
  logic               r_err, w_err_d;
  logic               r_stk_clk, w_stk_clk_d;
  logic [1:0]         r_stk_cmd, w_stk_cmd_d;
  logic [INDEX_W-1:0] r_stk_index, w_stk_index_d;
  logic               r_drive, w_drive_d;
  logic               r_stk_reset;

  logic               w_pick_b;
  logic [1:0]         w_req_cmd;
  logic [INDEX_W-1:0] w_req_index;
  logic [DATA_W-1:0]  w_req_wdata;
  logic               w_illegal;

  // Arbitration and legality of the request that would be granted this cycle
  always_comb begin
    w_pick_b    = B_REQ && (!A_REQ || !r_last);
    w_req_cmd   = w_pick_b ? B_CMD   : A_CMD;
    w_req_index = w_pick_b ? B_INDEX : A_INDEX;
    w_req_wdata = w_pick_b ? B_WDATA : A_WDATA;
    w_illegal   = 1'b0;
    unique case (w_req_cmd)
      CmdPush: w_illegal = (r_count == 3'(DEPTH));
      CmdPop:  w_illegal = (r_count == 3'd0);
      CmdGet:  w_illegal = (int'(w_req_index) >= int'(r_count));
      default: w_illegal = 1'b0;
    endcase
  end

  // Next state and next values of every registered output
  always_comb begin
    w_state_d     = r_state;
    w_cmd_d       = r_cmd;
    w_index_d     = r_index;
    w_wdata_d     = r_wdata;
    w_grant_d     = r_grant;
    w_last_d      = r_last;
    w_count_d     = r_count;
    w_rdata_d     = r_rdata;
    w_ack_d       = 2'b00;
    w_err_d       = 1'b0;
    w_stk_clk_d   = 1'b0;
    w_stk_cmd_d   = CmdNop;
    w_stk_index_d = r_stk_index;
    w_drive_d     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (A_REQ || B_REQ) begin
          w_grant_d = w_pick_b;
          w_cmd_d   = w_req_cmd;
          w_index_d = w_req_index;
          w_wdata_d = w_req_wdata;
          if (w_illegal || w_req_cmd == CmdNop) begin
            // No stack access: acknowledge on the very next cycle
            w_state_d = StRelease;
            w_ack_d   = w_pick_b ? 2'b10 : 2'b01;
            w_err_d   = w_illegal;
            w_last_d  = w_pick_b;
          end else begin
            w_state_d     = StSetup;
            w_stk_cmd_d   = w_req_cmd;
            w_stk_index_d = w_req_index;
            w_drive_d     = (w_req_cmd == CmdPush);
          end
        end
      end
      StSetup: begin
        w_state_d   = StStrobe;
        w_stk_clk_d = 1'b1;
        w_stk_cmd_d = r_cmd;
        w_drive_d   = (r_cmd == CmdPush);
      end
      StStrobe: begin
        w_state_d   = StCapture;
        w_stk_clk_d = 1'b1;
        w_stk_cmd_d = r_cmd;
        w_drive_d   = (r_cmd == CmdPush);
      end
      StCapture: begin
        w_state_d = StRelease;
        w_ack_d   = r_grant ? 2'b10 : 2'b01;
        w_last_d  = r_grant;
        if (r_cmd == CmdPop || r_cmd == CmdGet) w_rdata_d = STK_IO_DATA;
        if (r_cmd == CmdPush) w_count_d = r_count + 3'd1;
        if (r_cmd == CmdPop)  w_count_d = r_count - 3'd1;
      end
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    r_stk_reset <= RESET;
    if (RESET) begin
      r_state     <= StIdle;
      r_cmd       <= CmdNop;
      r_index     <= '0;
      r_wdata     <= '0;
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_count     <= 3'd0;
      r_rdata     <= '0;
      r_ack       <= 2'b00;
      r_err       <= 1'b0;
      r_stk_clk   <= 1'b0;
      r_stk_cmd   <= CmdNop;
      r_stk_index <= '0;
      r_drive     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cmd       <= w_cmd_d;
      r_index     <= w_index_d;
      r_wdata     <= w_wdata_d;
      r_grant     <= w_grant_d;
      r_last      <= w_last_d;
      r_count     <= w_count_d;
      r_rdata     <= w_rdata_d;
      r_ack       <= w_ack_d;
      r_err       <= w_err_d;
      r_stk_clk   <= w_stk_clk_d;
      r_stk_cmd   <= w_stk_cmd_d;
      r_stk_index <= w_stk_index_d;
      r_drive     <= w_drive_d;
    end
  end

  assign ACK         = r_ack;
  assign RDATA       = r_rdata;
  assign ERR         = r_err;
  assign COUNT       = r_count;
  assign EMPTY       = (r_count == 3'd0);
  assign FULL        = (r_count == 3'(DEPTH));
  assign STK_RESET   = r_stk_reset;
  assign STK_CLK     = r_stk_clk;
  assign STK_COMMAND = r_stk_cmd;
  assign STK_INDEX   = r_stk_index;
  // Only a push in SETUP/STROBE/CAPTURE ever drives the shared bus
  assign STK_IO_DATA = r_drive ? r_wdata : 'z;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 5-deep stack on the bus.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [1:0] a_cmd = 2'b00, b_cmd = 2'b00;
  logic [2:0] a_index = 3'd0, b_index = 3'd0;
  logic [3:0] a_wdata = 4'd0, b_wdata = 4'd0;
  logic [1:0] ack;
  logic [3:0] rdata;
  logic       err, empty, full, stk_reset, stk_clk;
  logic [2:0] count;
  logic [1:0] stk_cmd;
  logic [2:0] stk_index;
  wire  [3:0] stk_io;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  stack_arbiter dut (
    .CLK(clk), .RESET(rst),
    .A_REQ(a_req), .A_CMD(a_cmd), .A_INDEX(a_index), .A_WDATA(a_wdata),
    .B_REQ(b_req), .B_CMD(b_cmd), .B_INDEX(b_index), .B_WDATA(b_wdata),
    .ACK(ack), .RDATA(rdata), .ERR(err), .COUNT(count), .EMPTY(empty), .FULL(full),
    .STK_RESET(stk_reset), .STK_CLK(stk_clk), .STK_COMMAND(stk_cmd),
    .STK_INDEX(stk_index), .STK_IO_DATA(stk_io)
  );

  // Behavioural stack: acts on the strobe's rising edge, drives read data while strobe is high
  logic [3:0] mem [5];
  logic [3:0] stk_out = 4'd0;
  int         pulses = 0;
  assign stk_io = (stk_clk && stk_cmd[1]) ? stk_out : 4'bz;

  always @(posedge stk_clk or posedge stk_reset) begin
    if (stk_reset) begin
      for (int i = 0; i < 5; i++) mem[i] <= 4'd0;
    end else begin
      pulses <= pulses + 1;
      case (stk_cmd)
        2'b01: begin
          for (int i = 4; i > 0; i--) mem[i] <= mem[i-1];
          mem[0] <= stk_io;
        end
        2'b10: begin
          stk_out <= mem[0];
          for (int i = 0; i < 4; i++) mem[i] <= mem[i+1];
          mem[4] <= 4'd0;
        end
        2'b11: if (stk_index < 3'd5) stk_out <= mem[stk_index];
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit who, input logic req, input logic [1:0] cmd,
                         input logic [2:0] idx, input logic [3:0] wd);
    if (who) begin
      b_req = req; b_cmd = cmd; b_index = idx; b_wdata = wd;
    end else begin
      a_req = req; a_cmd = cmd; a_index = idx; a_wdata = wd;
    end
  endtask

  // Counts falling edges until ACK is seen, bounded
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == 2'b00 && lat < 20);
  endtask

  // One complete transaction from a single requester, checked on its ACK
  task automatic do_op(input string tag, input bit who, input logic [1:0] cmd,
                       input logic [2:0] idx, input logic [3:0] wd, input logic exp_err,
                       input logic [3:0] exp_rd, input logic [2:0] exp_cnt);
    int  lat;
    int  p0;
    bit  legal;
    legal = (cmd != 2'b00) && !exp_err;
    @(negedge clk);
    p0 = pulses;
    set_req(who, 1'b1, cmd, idx, wd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2 && legal && cmd == 2'b01) check_eq({tag, "_busdata"}, 32'(stk_io), 32'(wd));
    end while (ack == 2'b00 && lat < 20);
    check_eq({tag, "_lat"}, lat, legal ? 4 : 1);
    check_eq({tag, "_ack"}, 32'(ack), who ? 2 : 1);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
    check_eq({tag, "_count"}, 32'(count), 32'(exp_cnt));
    check_eq({tag, "_pulses"}, pulses - p0, legal ? 1 : 0);
    set_req(who, 1'b0, 2'b00, 3'd0, 4'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset held for two cycles
    @(negedge clk);
    check_eq("rst1_stk_reset", 32'(stk_reset), 1);
    @(negedge clk);
    check_eq("rst2_stk_reset", 32'(stk_reset), 1);
    check_eq("rst_stk_clk", 32'(stk_clk), 0);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_stk_cmd", 32'(stk_cmd), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_stk_reset", 32'(stk_reset), 0);

    // Fill the stack, then overflow
    for (int i = 1; i <= 5; i++) do_op($sformatf("push%0d", i), 1'b0, 2'b01, 3'd0, 4'(i), 1'b0, 4'd0, 3'(i));
    check_eq("full_after_5", 32'(full), 1);
    do_op("push_over", 1'b0, 2'b01, 3'd0, 4'd6, 1'b1, 4'd0, 3'd5);

    // Pops and gets; stack afterwards is 3,2,1 from the top
    do_op("pop5", 1'b0, 2'b10, 3'd0, 4'd0, 1'b0, 4'd5, 3'd4);
    do_op("pop4", 1'b0, 2'b10, 3'd0, 4'd0, 1'b0, 4'd4, 3'd3);
    do_op("get0", 1'b0, 2'b11, 3'd0, 4'd0, 1'b0, 4'd3, 3'd3);
    do_op("get2", 1'b0, 2'b11, 3'd2, 4'd0, 1'b0, 4'd1, 3'd3);
    do_op("get3", 1'b0, 2'b11, 3'd3, 4'd0, 1'b1, 4'd1, 3'd3);
    do_op("nop", 1'b1, 2'b00, 3'd0, 4'd0, 1'b0, 4'd1, 3'd3);

    // Simultaneous requests: A push 7, B pop
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b01, 3'd0, 4'd7);
    set_req(1'b1, 1'b1, 2'b10, 3'd0, 4'd0);
    wait_ack(lat);
    check_eq("both_a_lat", lat, 4);
    check_eq("both_a_ack", 32'(ack), 1);
    check_eq("both_a_count", 32'(count), 4);
    set_req(1'b0, 1'b0, 2'b00, 3'd0, 4'd0);
    wait_ack(lat);
    check_eq("both_b_lat", lat, 5);
    check_eq("both_b_ack", 32'(ack), 2);
    check_eq("both_b_rdata", 32'(rdata), 7);
    check_eq("both_b_count", 32'(count), 3);
    set_req(1'b1, 1'b0, 2'b00, 3'd0, 4'd0);
    // Both again: A gets next
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b11, 3'd0, 4'd0);
    set_req(1'b1, 1'b1, 2'b11, 3'd2, 4'd0);
    wait_ack(lat);
    check_eq("alt_a_ack", 32'(ack), 1);
    check_eq("alt_a_rdata", 32'(rdata), 3);
    set_req(1'b0, 1'b0, 2'b00, 3'd0, 4'd0);
    wait_ack(lat);
    check_eq("alt_b_ack", 32'(ack), 2);
    check_eq("alt_b_rdata", 32'(rdata), 1);
    set_req(1'b1, 1'b0, 2'b00, 3'd0, 4'd0);

    // Drain, then pop on empty from B
    do_op("drain3", 1'b0, 2'b10, 3'd0, 4'd0, 1'b0, 4'd3, 3'd2);
    do_op("drain2", 1'b0, 2'b10, 3'd0, 4'd0, 1'b0, 4'd2, 3'd1);
    do_op("drain1", 1'b0, 2'b10, 3'd0, 4'd0, 1'b0, 4'd1, 3'd0);
    check_eq("empty_after_drain", 32'(empty), 1);
    do_op("pop_empty", 1'b1, 2'b10, 3'd0, 4'd0, 1'b1, 4'd1, 3'd0);

    // Push 9, then reset during STROBE
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b01, 3'd0, 4'd9);
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_in_strobe", 32'(stk_clk), 1);
    rst = 1'b1;
    set_req(1'b0, 1'b0, 2'b00, 3'd0, 4'd0);
    @(negedge clk);
    check_eq("abort_stk_clk", 32'(stk_clk), 0);
    check_eq("abort_stk_reset", 32'(stk_reset), 1);
    check_eq("abort_count", 32'(count), 0);
    check_eq("abort_stk_cmd", 32'(stk_cmd), 0);
    seen = (ack != 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | (ack != 2'b00);
    end
    check_eq("abort_no_ack", 32'(seen), 0);
    do_op("pop_after_abort", 1'b0, 2'b10, 3'd0, 4'd0, 1'b1, 4'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
